// File: rtl/motoro3_line_pkg.sv
// Shared types and widths for the motor line PWM sequencer.
package motoro3_line_pkg;
  localparam int LC_STEP_MAX_DEF = 11;
  localparam int DEAD_CYC_DEF    = 4;
  localparam int LEN_W           = 16;
  localparam int PWM_W           = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } line_state_e;
endpackage

// File: rtl/motoro3_pwm_period_cnt.sv
// PWM period counter: counts 0..period-1, flags the wrap and compares against the on-length.
module motoro3_pwm_period_cnt
  import motoro3_line_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [PWM_W-1:0] period,
  input  logic [LEN_W-1:0] pl_lat,
  output logic             pwm_raw,
  output logic             wrap
);
  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic             period_nz;

  assign period_nz = (period != '0);
  // >= rather than == so a period lowered below the current count still wraps.
  assign wrap      = en && period_nz && (pwm_cnt_q >= (period - PWM_W'(1)));
  assign pwm_raw   = period_nz && ({{(LEN_W-PWM_W){1'b0}}, pwm_cnt_q} < pl_lat);

  always_comb begin
    pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
    if (!en || !period_nz || wrap) pwm_cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_cnt_q <= '0;
    else     pwm_cnt_q <= pwm_cnt_d;
  end
endmodule

// File: rtl/motoro3_line_pwm_sequencer.sv
// Step sequencer and PWM driver for one motor line; optional dead-time pair
// output is enabled with `define MOTORO3_LINE_DEADTIME_EN.
//
// Handshake: none; slLen/plLen are combinational returns on lcStep/m3LpwmStep and
// are sampled only in the LOAD cycle that follows a step change.
module motoro3_line_pwm_sequencer
  import motoro3_line_pkg::*;
#(
  parameter int LC_STEP_MAX = LC_STEP_MAX_DEF,
  parameter int DEAD_CYC    = DEAD_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m3r_enable,
  input  logic [PWM_W-1:0] m3r_pwmLenWant,
  input  logic [1:0]       m3r_stepSplitMax,
  input  logic [LEN_W-1:0] slLen,
  input  logic [LEN_W-1:0] plLen,
  output logic [3:0]       lcStep,
  output logic [1:0]       m3LpwmStep,
  output logic             pwmOut,
  output logic             pwmOutN,
  output logic             stepPulse,
  output logic             busy,
  output line_state_e      dbg_state
);
  line_state_e      state_q, state_d;
  logic [3:0]       lc_q, lc_d;
  logic [1:0]       sub_q, sub_d;
  logic [LEN_W-1:0] seg_q, seg_d;
  logic [LEN_W-1:0] pl_q, pl_d;
  logic             ideal_q, ideal_d;
  logic             pulse_q, pulse_d;
  logic             busy_q, busy_d;
  logic             cnt_en, pwm_raw, wrap;

  assign cnt_en = (state_q != IDLE) && m3r_enable;

  motoro3_pwm_period_cnt u_period (
    .clk     (clk),
    .rst     (rst),
    .en      (cnt_en),
    .period  (m3r_pwmLenWant),
    .pl_lat  (pl_q),
    .pwm_raw (pwm_raw),
    .wrap    (wrap)
  );

  always_comb begin
    state_d = state_q;
    lc_d    = lc_q;
    sub_d   = sub_q;
    seg_d   = seg_q;
    pl_d    = pl_q;
    ideal_d = 1'b0;
    pulse_d = 1'b0;
    if (!m3r_enable) begin
      state_d = IDLE;
      seg_d   = '0;
    end else begin
      case (state_q)
        IDLE: state_d = LOAD;
        LOAD: begin
          // Compare still uses the previous on-length so the boundary is glitch-free.
          ideal_d = pwm_raw;
          pl_d    = plLen;
          seg_d   = (slLen == '0) ? '0 : slLen - LEN_W'(1);
          state_d = RUN;
        end
        RUN: begin
          ideal_d = pwm_raw;
          if (wrap) begin
            if (seg_q == '0) begin
              state_d = LOAD;
              if (sub_q < m3r_stepSplitMax) begin
                sub_d = sub_q + 2'd1;
              end else begin
                sub_d   = 2'd0;
                lc_d    = (lc_q >= 4'(LC_STEP_MAX)) ? 4'd0 : lc_q + 4'd1;
                pulse_d = 1'b1;
              end
            end else begin
              seg_d = seg_q - LEN_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lc_q    <= '0;
      sub_q   <= '0;
      seg_q   <= '0;
      pl_q    <= '0;
      ideal_q <= 1'b0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lc_q    <= lc_d;
      sub_q   <= sub_d;
      seg_q   <= seg_d;
      pl_q    <= pl_d;
      ideal_q <= ideal_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
    end
  end

  assign lcStep     = lc_q;
  assign m3LpwmStep = sub_q;
  assign stepPulse  = pulse_q;
  assign busy       = busy_q;
  assign dbg_state  = state_q;

`ifdef MOTORO3_LINE_DEADTIME_EN
  logic       hi_q, hi_d, lo_q, lo_d;
  logic [7:0] dead_q, dead_d;

  // A side may only turn on after both sides have been low for DEAD_CYC cycles.
  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    dead_d = dead_q;
    if (!m3r_enable || !busy_q) begin
      hi_d   = 1'b0;
      lo_d   = 1'b0;
      dead_d = '0;
    end else if (hi_q) begin
      hi_d   = ideal_q;
      dead_d = '0;
    end else if (lo_q) begin
      lo_d   = !ideal_q;
      dead_d = '0;
    end else if (dead_q >= 8'(DEAD_CYC)) begin
      hi_d = ideal_q;
      lo_d = !ideal_q;
    end else begin
      dead_d = dead_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q   <= 1'b0;
      lo_q   <= 1'b0;
      dead_q <= '0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      dead_q <= dead_d;
    end
  end

  assign pwmOut  = hi_q;
  assign pwmOutN = lo_q;
`else
  logic unused_dead_cfg;
  assign unused_dead_cfg = (DEAD_CYC < 0);
  assign pwmOut  = ideal_q;
  assign pwmOutN = 1'b0;
`endif
endmodule

// File: tb/tb_motoro3_line_pwm_sequencer.sv
// Self-checking bench for motoro3_line_pwm_sequencer against a behavioural line model.
module tb_motoro3_line_pwm_sequencer;
  import motoro3_line_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [11:0] per = '0;
  logic [1:0]  split = '0;
  logic [15:0] sl_tab [64];
  logic [15:0] pl_tab [64];
  logic [15:0] slLen, plLen;
  logic [3:0]  lcStep;
  logic [1:0]  m3LpwmStep;
  logic        pwmOut, pwmOutN, stepPulse, busy;
  line_state_e dbg_state;

  int n_checks = 0;
  int n_err    = 0;

  // Behavioural model: mode 0=idle, 1=load, 2=run
  int m_mode, m_cnt, m_seg, m_pl, m_lc, m_sub;
  bit m_out, m_pulse;
  int low_run;
  bit prev_hi, prev_lo;

  always #5 clk = ~clk;

  assign slLen = sl_tab[{lcStep, m3LpwmStep}];
  assign plLen = pl_tab[{lcStep, m3LpwmStep}];

  motoro3_line_pwm_sequencer dut (
    .clk              (clk),
    .rst              (rst),
    .m3r_enable       (en),
    .m3r_pwmLenWant   (per),
    .m3r_stepSplitMax (split),
    .slLen            (slLen),
    .plLen            (plLen),
    .lcStep           (lcStep),
    .m3LpwmStep       (m3LpwmStep),
    .pwmOut           (pwmOut),
    .pwmOutN          (pwmOutN),
    .stepPulse        (stepPulse),
    .busy             (busy),
    .dbg_state        (dbg_state)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_checks++;
    n_err++;
    $error("FAIL %s timeout observed=expired expected=event", tag);
  endtask

  task automatic fill_tab(input int sl, input int pl);
    for (int i = 0; i < 64; i++) begin
      sl_tab[i] = 16'(sl);
      pl_tab[i] = 16'(pl);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_seg = 0; m_pl = 0; m_lc = 0; m_sub = 0;
    m_out = 0; m_pulse = 0;
  endtask

  // One clock of the line rules, using the inputs present at the edge.
  task automatic model_edge();
    int  p, sl_now, pl_now;
    bit  wrapped;
    p      = int'(per);
    sl_now = int'(sl_tab[m_lc * 4 + m_sub]);
    pl_now = int'(pl_tab[m_lc * 4 + m_sub]);
    m_pulse = 0;
    if (!en) begin
      m_mode = 0; m_cnt = 0; m_seg = 0; m_out = 0;
    end else if (m_mode == 0) begin
      m_mode = 1; m_cnt = 0; m_out = 0;
    end else begin
      m_out   = (p != 0) && (m_cnt < m_pl);
      wrapped = (p != 0) && (m_cnt >= p - 1);
      m_cnt   = (p == 0 || wrapped) ? 0 : m_cnt + 1;
      if (m_mode == 1) begin
        m_pl   = pl_now;
        m_seg  = (sl_now > 1) ? sl_now - 1 : 0;
        m_mode = 2;
      end else if (wrapped) begin
        if (m_seg == 0) begin
          m_mode = 1;
          if (m_sub < int'(split)) m_sub = m_sub + 1;
          else begin
            m_sub   = 0;
            m_lc    = (m_lc >= 11) ? 0 : m_lc + 1;
            m_pulse = 1;
          end
        end else begin
          m_seg = m_seg - 1;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("lcStep", int'(lcStep), m_lc);
    chk("m3LpwmStep", int'(m3LpwmStep), m_sub);
    chk("stepPulse", int'(stepPulse), int'(m_pulse));
    chk("busy", int'(busy), (m_mode != 0) ? 1 : 0);
`ifdef MOTORO3_LINE_DEADTIME_EN
    chk("no_overlap", int'(pwmOut && pwmOutN), 0);
    if ((pwmOut && !prev_hi) || (pwmOutN && !prev_lo)) chk("dead_gap_ok", int'(low_run >= 4), 1);
    if (!pwmOut && !pwmOutN) low_run++;
    else low_run = 0;
    prev_hi = pwmOut;
    prev_lo = pwmOutN;
`else
    chk("pwmOut", int'(pwmOut), int'(m_out));
    chk("pwmOutN", int'(pwmOutN), 0);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int cyc;
    bit found;
    model_reset();
    low_run = 0; prev_hi = 0; prev_lo = 0;
    fill_tab(2, 3);

    // Reset state
    #2;
    chk("rst_lcStep", int'(lcStep), 0);
    chk("rst_pwmOut", int'(pwmOut), 0);
    chk("rst_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;

    // Period 10, on 3, segment 2 periods: first advance after 21 edges
    per = 12'd10; split = 2'd0; en = 1'b1;
    cyc = 0; found = 0;
    while (!found && cyc < 100) begin
      tick();
      cyc++;
      if (stepPulse) found = 1;
    end
    if (!found) timeout("first_step");
    else chk("first_step_cycle", cyc, 21);
    chk("first_step_lc", int'(lcStep), 1);
    run(40);

    // Asynchronous reset mid-RUN while the PWM is high
    cyc = 0;
    while (!m_out && cyc < 40) begin tick(); cyc++; end
    if (!m_out) timeout("wait_pwm_high");
    #2 rst = 1'b1;
    #1;
    chk("arst_pwmOut", int'(pwmOut), 0);
    chk("arst_lcStep", int'(lcStep), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_stepPulse", int'(stepPulse), 0);
    model_reset();
    #1 rst = 1'b0;
    run(10);

    // Sub-step sequencing with full lcStep wrap (36 advances of 4 cycles)
    fill_tab(1, 2); per = 12'd4; split = 2'd2;
    run(160);

    // Boundaries: slLen=0 as 1, plLen beyond period, period 0
    fill_tab(0, 20); per = 12'd10; split = 2'd0;
    run(60);
    chk("full_on", int'(pwmOut), 1);
    per = 12'd0;
    run(40);
    chk("period0_off", int'(pwmOut), 0);
    chk("period0_no_step", int'(lcStep), m_lc);

    // Enable dropped at 5/1, then resumed
    fill_tab(1, 1); per = 12'd4; split = 2'd2;
    cyc = 0;
    while (!(m_lc == 5 && m_sub == 1 && m_mode == 2) && cyc < 600) begin tick(); cyc++; end
    if (!(m_lc == 5 && m_sub == 1)) timeout("wait_5_1");
    en = 1'b0;
    tick();
    chk("drop_busy", int'(busy), 0);
    chk("drop_pwmOut", int'(pwmOut), 0);
    chk("drop_lc", int'(lcStep), 5);
    chk("drop_sub", int'(m3LpwmStep), 1);
    run(5);
    en = 1'b1;
    tick();
    chk("resume_busy", int'(busy), 1);
    chk("resume_lc", int'(lcStep), 5);
    chk("resume_sub", int'(m3LpwmStep), 1);
    run(20);

    // Randomized tables, period, split and enable
    for (int blk = 0; blk < 6; blk++) begin
      for (int i = 0; i < 64; i++) begin
        sl_tab[i] = 16'($urandom_range(0, 3));
        pl_tab[i] = 16'($urandom_range(0, 14));
      end
      for (int c = 0; c < 500; c++) begin
        if ($urandom_range(0, 99) == 0) per = 12'($urandom_range(0, 12));
        if ($urandom_range(0, 79) == 0) split = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 59) == 0) en = ~en;
        tick();
      end
      en = 1'b1;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
